// File: rtl/mure_itype_resolver_pkg.sv
// Shared types and decode constants for the multi-retire itype resolver.
package mure_itype_resolver_pkg;

  localparam int XLEN      = 32;
  localparam int INST_LEN  = 32;
  localparam int CAUSE_LEN = 5;
  localparam int PRIV_LEN  = 2;

  typedef enum logic [3:0] {
    IT_STD  = 4'd0,
    IT_EXC  = 4'd1,
    IT_INT  = 4'd2,
    IT_ERET = 4'd3,
    IT_NTB  = 4'd4,
    IT_TB   = 4'd5,
    IT_UIJ3 = 4'd6,
    IT_RSV7 = 4'd7,
    IT_UC   = 4'd8,
    IT_IC   = 4'd9,
    IT_UIJ  = 4'd10,
    IT_IJ   = 4'd11,
    IT_CRS  = 4'd12,
    IT_RET  = 4'd13,
    IT_OUIJ = 4'd14,
    IT_OIJ  = 4'd15
  } itype4_e;

  // Classified entry handed to the uop FIFO; itype is always 4 bits wide,
  // 3-bit encodings are zero-extended.
  typedef struct packed {
    logic [3:0]           itype;
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } uop_entry_s;

  // Raw retired instruction held until its successor PC is known.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic                 compressed;
    logic                 exception;
    logic                 interrupt;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } pend_entry_s;

  localparam logic [31:0] MASK_JAL     = 32'h0000_007f;
  localparam logic [31:0] MATCH_JAL    = 32'h0000_006f;
  localparam logic [31:0] MASK_JALR    = 32'h0000_707f;
  localparam logic [31:0] MATCH_JALR   = 32'h0000_0067;
  localparam logic [31:0] MASK_BRANCH  = 32'h0000_007f;
  localparam logic [31:0] MATCH_BRANCH = 32'h0000_0063;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;
  localparam logic [31:0] INST_SRET    = 32'h1020_0073;
  localparam logic [31:0] INST_URET    = 32'h0020_0073;

  localparam logic [15:0] MASK_C_J      = 16'he003;
  localparam logic [15:0] MATCH_C_J     = 16'ha001;
  localparam logic [15:0] MASK_C_JAL    = 16'he003;
  localparam logic [15:0] MATCH_C_JAL   = 16'h2001;
  localparam logic [15:0] MASK_C_JR     = 16'hf07f;
  localparam logic [15:0] MATCH_C_JR    = 16'h8002;
  localparam logic [15:0] MASK_C_JALR   = 16'hf07f;
  localparam logic [15:0] MATCH_C_JALR  = 16'h9002;
  localparam logic [15:0] MASK_C_BEQZ   = 16'he003;
  localparam logic [15:0] MATCH_C_BEQZ  = 16'hc001;
  localparam logic [15:0] MASK_C_BNEZ   = 16'he003;
  localparam logic [15:0] MATCH_C_BNEZ  = 16'he001;

  localparam logic [4:0] X_ZERO = 5'd0;
  localparam logic [4:0] X_RA   = 5'd1;
  localparam logic [4:0] X_T0   = 5'd5;

  // Link registers are ra and t0.
  function automatic logic is_link(input logic [4:0] r);
    return (r == X_RA) || (r == X_T0);
  endfunction

endpackage

// File: rtl/mure_itype_resolver_if.sv
// Retire-side and uop-side signal bundle of the itype resolver.
interface mure_itype_resolver_if
  import mure_itype_resolver_pkg::*;
#(
  parameter int NRET = 2
) ();

  logic [NRET-1:0]                valid_i;
  logic [NRET-1:0][XLEN-1:0]      pc_i;
  logic [NRET-1:0][INST_LEN-1:0]  inst_data_i;
  logic [NRET-1:0]                compressed_i;
  logic [NRET-1:0]                exception_i;
  logic [NRET-1:0]                interrupt_i;
  logic [CAUSE_LEN-1:0]           cause_i;
  logic [XLEN-1:0]                tval_i;
  logic [PRIV_LEN-1:0]            priv_i;
  logic                           flush_i;
  logic [NRET-1:0]                valid_o;
  uop_entry_s [NRET-1:0]          uop_o;
  logic                           pending_o;

  modport master (
    output valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
           cause_i, tval_i, priv_i, flush_i,
    input  valid_o, uop_o, pending_o
  );

  modport slave (
    input  valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
           cause_i, tval_i, priv_i, flush_i,
    output valid_o, uop_o, pending_o
  );

endinterface

// File: rtl/mure_itype_resolver_classify.sv
// Combinational itype classifier for one retired instruction.
module mure_itype_resolver_classify
  import mure_itype_resolver_pkg::*;
#(
  parameter int ITYPE_LEN = 3
) (
  input  logic [INST_LEN-1:0] inst,
  input  logic                compressed,
  input  logic                exception,
  input  logic                interrupt,
  input  logic                taken,
  output logic [3:0]          itype
);

  logic [15:0] cinst;
  logic        is_eret;
  logic        is_branch;
  logic        is_uninf;
  logic        is_inf;
  logic [4:0]  rd;
  logic [4:0]  rs1;

  assign cinst = inst[15:0];

  // Instruction decode: control-flow class plus the rd/rs1 used for link hints.
  always_comb begin
    is_eret   = 1'b0;
    is_branch = 1'b0;
    is_uninf  = 1'b0;
    is_inf    = 1'b0;
    rd        = inst[11:7];
    rs1       = inst[19:15];
    if (compressed) begin
      is_branch = ((cinst & MASK_C_BEQZ) == MATCH_C_BEQZ) ||
                  ((cinst & MASK_C_BNEZ) == MATCH_C_BNEZ);
      // rs1 of zero in these slots encodes a different instruction (e.g. C.EBREAK)
      if (((cinst & MASK_C_JR) == MATCH_C_JR) && (cinst[11:7] != X_ZERO)) begin
        is_uninf = 1'b1;
        rd       = X_ZERO;
        rs1      = cinst[11:7];
      end
      if (((cinst & MASK_C_JALR) == MATCH_C_JALR) && (cinst[11:7] != X_ZERO)) begin
        is_uninf = 1'b1;
        rd       = X_RA;
        rs1      = cinst[11:7];
      end
      if ((cinst & MASK_C_J) == MATCH_C_J) begin
        is_inf = 1'b1;
        rd     = X_ZERO;
      end
      if ((cinst & MASK_C_JAL) == MATCH_C_JAL) begin
        is_inf = 1'b1;
        rd     = X_RA;
      end
    end else begin
      is_eret   = (inst == INST_MRET) || (inst == INST_SRET) || (inst == INST_URET);
      // funct3 010/011 are not branch encodings
      is_branch = ((inst & MASK_BRANCH) == MATCH_BRANCH) && (inst[14:13] != 2'b01);
      is_uninf  = (inst & MASK_JALR) == MATCH_JALR;
      is_inf    = (inst & MASK_JAL) == MATCH_JAL;
    end
  end

  // Priority resolution of the itype code.
  always_comb begin
    itype = IT_STD;
    if (exception) begin
      itype = IT_EXC;
    end else if (interrupt) begin
      itype = IT_INT;
    end else if (is_eret) begin
      itype = IT_ERET;
    end else if (is_branch) begin
      itype = taken ? IT_TB : IT_NTB;
    end else if (is_uninf) begin
      if (ITYPE_LEN == 4) begin
        if (is_link(rd) && is_link(rs1) && (rd != rs1)) itype = IT_CRS;
        else if (is_link(rd))                            itype = IT_UC;
        else if (is_link(rs1))                           itype = IT_RET;
        else if (rd == X_ZERO)                           itype = IT_UIJ;
        else                                             itype = IT_OUIJ;
      end else begin
        itype = IT_UIJ3;
      end
    end else if (is_inf && (ITYPE_LEN == 4)) begin
      if (is_link(rd))       itype = IT_IC;
      else if (rd == X_ZERO) itype = IT_IJ;
      else                   itype = IT_OIJ;
    end
  end

endmodule

// File: rtl/mure_itype_resolver.sv
// Multi-retire itype resolver: classifies retired instructions, holding the
// youngest one until its successor PC resolves branch direction.
module mure_itype_resolver
  import mure_itype_resolver_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int ITYPE_LEN = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  mure_itype_resolver_if.slave bus
);

  localparam int IDX_W = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int CNT_W = $clog2(NRET + 1);

  pend_entry_s                pend_q;
  logic                       pend_vld_q;
  logic                       flush_lat_q;
  logic                       any_vld;
  logic                       do_flush;
  logic [CNT_W-1:0]           m_cnt;
  logic [IDX_W-1:0]           last_idx;
  pend_entry_s                last_lane;
  logic [NRET-1:0]            lane_taken;
  logic [NRET-1:0][3:0]       lane_itype;
  uop_entry_s [NRET-1:0]      lane_uop;
  logic                       pend_taken;
  logic [3:0]                 pend_itype;
  uop_entry_s                 pend_uop;
  logic [NRET-1:0]            nxt_valid;
  uop_entry_s [NRET-1:0]      nxt_uop;

  function automatic logic [XLEN-1:0] pc_step(input logic c);
    return c ? XLEN'(2) : XLEN'(4);
  endfunction

  // Trap fields travel only with trap entries so downstream sees clean zeros.
  function automatic uop_entry_s build_uop(
    input logic [3:0]           it,
    input logic [XLEN-1:0]      pc,
    input logic [INST_LEN-1:0]  inst,
    input logic [CAUSE_LEN-1:0] cause,
    input logic [XLEN-1:0]      tval,
    input logic [PRIV_LEN-1:0]  priv
  );
    uop_entry_s u;
    u       = '0;
    u.itype = it;
    u.pc    = pc;
    u.inst  = inst;
    if ((it == IT_EXC) || (it == IT_INT)) begin
      u.cause = cause;
      u.tval  = tval;
      u.priv  = priv;
    end
    return u;
  endfunction

  assign any_vld       = |bus.valid_i;
  assign do_flush      = bus.flush_i | flush_lat_q;
  assign bus.pending_o = pend_vld_q;

  for (genvar k = 0; k < NRET; k++) begin : g_lane
    if (k < NRET - 1) begin : g_succ
      assign lane_taken[k] = bus.pc_i[k+1] != (bus.pc_i[k] + pc_step(bus.compressed_i[k]));
    end else begin : g_last
      // The last lane is never emitted directly; it is always held as pending.
      assign lane_taken[k] = 1'b0;
    end

    mure_itype_resolver_classify #(.ITYPE_LEN(ITYPE_LEN)) u_cls (
      .inst       (bus.inst_data_i[k]),
      .compressed (bus.compressed_i[k]),
      .exception  (bus.exception_i[k]),
      .interrupt  (bus.interrupt_i[k]),
      .taken      (lane_taken[k]),
      .itype      (lane_itype[k])
    );

    assign lane_uop[k] = build_uop(lane_itype[k], bus.pc_i[k], bus.inst_data_i[k],
                                   bus.cause_i, bus.tval_i, bus.priv_i);
  end

  // A flush resolves the held entry with no successor, i.e. not taken.
  assign pend_taken = bus.valid_i[0] &
                      (bus.pc_i[0] != (pend_q.pc + pc_step(pend_q.compressed)));

  mure_itype_resolver_classify #(.ITYPE_LEN(ITYPE_LEN)) u_cls_pend (
    .inst       (pend_q.inst),
    .compressed (pend_q.compressed),
    .exception  (pend_q.exception),
    .interrupt  (pend_q.interrupt),
    .taken      (pend_taken),
    .itype      (pend_itype)
  );

  assign pend_uop = build_uop(pend_itype, pend_q.pc, pend_q.inst,
                              pend_q.cause, pend_q.tval, pend_q.priv);

  // Count valid lanes and pick the youngest one, which becomes the new pending entry.
  always_comb begin
    m_cnt     = '0;
    last_idx  = '0;
    last_lane = '0;
    for (int k = 0; k < NRET; k++) begin
      if (bus.valid_i[k]) begin
        m_cnt    = m_cnt + CNT_W'(1);
        last_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < NRET; k++) begin
      if (IDX_W'(k) == last_idx) begin
        last_lane.pc         = bus.pc_i[k];
        last_lane.inst       = bus.inst_data_i[k];
        last_lane.compressed = bus.compressed_i[k];
        last_lane.exception  = bus.exception_i[k];
        last_lane.interrupt  = bus.interrupt_i[k];
      end
    end
    last_lane.cause = bus.cause_i;
    last_lane.tval  = bus.tval_i;
    last_lane.priv  = bus.priv_i;
  end

  // Output packing: pending entry first, then lanes 0..m-2 shifted up behind it.
  always_comb begin
    nxt_valid = '0;
    nxt_uop   = '0;
    if (any_vld) begin
      for (int j = 0; j < NRET; j++) begin
        if (pend_vld_q && (j == 0)) begin
          nxt_valid[j] = 1'b1;
          nxt_uop[j]   = pend_uop;
        end else begin
          for (int k = 0; k < NRET; k++) begin
            if (((k + int'(pend_vld_q)) == j) && ((k + 1) < int'(m_cnt))) begin
              nxt_valid[j] = 1'b1;
              nxt_uop[j]   = lane_uop[k];
            end
          end
        end
      end
    end else if (pend_vld_q && do_flush) begin
      nxt_valid[0] = 1'b1;
      nxt_uop[0]   = pend_uop;
    end
  end

  // Output register, pending entry and deferred-flush latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.valid_o <= '0;
      bus.uop_o   <= '0;
      pend_vld_q  <= 1'b0;
      flush_lat_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      bus.valid_o <= nxt_valid;
      bus.uop_o   <= nxt_uop;
      if (any_vld) begin
        pend_vld_q  <= 1'b1;
        pend_q      <= last_lane;
        flush_lat_q <= flush_lat_q | bus.flush_i;
      end else if (do_flush) begin
        pend_vld_q  <= 1'b0;
        flush_lat_q <= 1'b0;
      end
    end
  end

  a_contiguous: assert property (@(posedge clk_i) disable iff (rst_i)
    ((bus.valid_i & (bus.valid_i + NRET'(1))) == '0));

  a_one_trap: assert property (@(posedge clk_i) disable iff (rst_i)
    ($countones({bus.valid_i & bus.exception_i, bus.valid_i & bus.interrupt_i}) <= 1));

endmodule

// File: tb/tb_mure_itype_resolver.sv
// Scoreboard bench: one resolver per itype width driven with identical retire streams.
module tb_mure_itype_resolver;
  import mure_itype_resolver_pkg::*;

  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_BNE   = 32'h0000_1063;
  localparam logic [31:0] I_BGE   = 32'h0000_5063;
  localparam logic [31:0] I_ADD   = 32'h0031_00b3;
  localparam logic [31:0] I_JALR  = 32'h0002_80e7; // jalr x1, 0(x5)
  localparam logic [31:0] I_RET   = 32'h0000_8067; // jalr x0, 0(x1)
  localparam logic [31:0] I_JAL   = 32'h0000_00ef; // jal x1, 0
  localparam logic [31:0] I_CJR   = 32'h0000_8302; // c.jr x6
  localparam logic [31:0] I_CJALR = 32'h0000_9502; // c.jalr x10
  localparam logic [31:0] I_MRET  = 32'h3020_0073;
  localparam logic [31:0] I_CBEQZ = 32'h0000_c001;
  localparam logic [31:0] I_CBNEZ = 32'h0000_e001;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       valid = '0;
  logic [1:0][31:0] pc    = '0;
  logic [1:0][31:0] inst  = '0;
  logic [1:0]       cmp   = '0;
  logic [1:0]       exc   = '0;
  logic [1:0]       intr  = '0;
  logic [4:0]       cause = '0;
  logic [31:0]      tval  = '0;
  logic [1:0]       priv  = '0;
  logic             flush = 1'b0;

  int ncmp  = 0;
  int nfail = 0;

  uop_entry_s exp3[$];
  uop_entry_s exp4[$];

  mure_itype_resolver_if #(.NRET(2)) if3 ();
  mure_itype_resolver_if #(.NRET(2)) if4 ();

  assign if3.valid_i = valid;       assign if4.valid_i = valid;
  assign if3.pc_i = pc;             assign if4.pc_i = pc;
  assign if3.inst_data_i = inst;    assign if4.inst_data_i = inst;
  assign if3.compressed_i = cmp;    assign if4.compressed_i = cmp;
  assign if3.exception_i = exc;     assign if4.exception_i = exc;
  assign if3.interrupt_i = intr;    assign if4.interrupt_i = intr;
  assign if3.cause_i = cause;       assign if4.cause_i = cause;
  assign if3.tval_i = tval;         assign if4.tval_i = tval;
  assign if3.priv_i = priv;         assign if4.priv_i = priv;
  assign if3.flush_i = flush;       assign if4.flush_i = flush;

  mure_itype_resolver #(.NRET(2), .ITYPE_LEN(3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3)
  );

  mure_itype_resolver #(.NRET(2), .ITYPE_LEN(4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
    ncmp++;
    if (got !== need) begin
      nfail++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Expected entry for both widths; trap fields default to zero.
  task automatic push(input logic [3:0] it3, input logic [3:0] it4, input logic [31:0] p,
                      input logic [31:0] i, input logic [4:0] c = '0,
                      input logic [31:0] tv = '0, input logic [1:0] pr = '0);
    uop_entry_s u;
    u.pc = p; u.inst = i; u.cause = c; u.tval = tv; u.priv = pr;
    u.itype = it3; exp3.push_back(u);
    u.itype = it4; exp4.push_back(u);
  endtask

  task automatic check_out(input int d, input int lane, input uop_entry_s got);
    uop_entry_s need;
    ncmp++;
    if ((d == 0 && exp3.size() == 0) || (d == 1 && exp4.size() == 0)) begin
      nfail++;
      $display("FAIL unexpected_out dut%0d lane%0d: got it=%0d pc=%h, need no output",
               d, lane, got.itype, got.pc);
    end else begin
      need = (d == 0) ? exp3.pop_front() : exp4.pop_front();
      if (got !== need) begin
        nfail++;
        $display("FAIL uop dut%0d lane%0d: got it=%0d pc=%h inst=%h cause=%0d tval=%h priv=%0d, need it=%0d pc=%h inst=%h cause=%0d tval=%h priv=%0d",
                 d, lane, got.itype, got.pc, got.inst, got.cause, got.tval, got.priv,
                 need.itype, need.pc, need.inst, need.cause, need.tval, need.priv);
      end
    end
  endtask

  // Monitor for the 3-bit resolver: lanes are consumed oldest first.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) if (if3.valid_o[j] === 1'b1) check_out(0, j, if3.uop_o[j]);
  end

  // Monitor for the 4-bit resolver.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) if (if4.valid_o[j] === 1'b1) check_out(1, j, if4.uop_o[j]);
  end

  task automatic lane(input int k, input logic [31:0] p, input logic [31:0] i, input logic c = 1'b0);
    pc[k] = p; inst[k] = i; cmp[k] = c;
  endtask

  task automatic step(input logic [1:0] v, input logic f = 1'b0);
    valid = v; flush = f;
    @(posedge clk); #1;
    valid = '0; flush = 1'b0; exc = '0; intr = '0;
    cause = '0; tval = '0; priv = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid3", 64'(if3.valid_o), 64'd0);
    chk("reset_pend3", 64'(if3.pending_o), 64'd0);
    chk("reset_valid4", 64'(if4.valid_o), 64'd0);
    chk("reset_pend4", 64'(if4.pending_o), 64'd0);

    // BEQ falls through to ADD -> NTB; ADD emitted once its successor arrives.
    lane(0, 32'h100, I_BEQ); lane(1, 32'h104, I_ADD);
    push(4'd4, 4'd4, 32'h100, I_BEQ);
    step(2'b11);
    lane(0, 32'h108, I_ADD);
    push(4'd0, 4'd0, 32'h104, I_ADD);
    step(2'b01);

    // BNE held across an idle gap, taken because successor is 0x180.
    lane(0, 32'h200, I_BNE);
    push(4'd0, 4'd0, 32'h108, I_ADD);
    step(2'b01);
    step(2'b00);
    chk("gap_pend_a", 64'(if4.pending_o), 64'd1);
    step(2'b00);
    chk("gap_pend_b", 64'(if3.pending_o), 64'd1);
    lane(0, 32'h180, I_ADD);
    push(4'd5, 4'd5, 32'h200, I_BNE);
    step(2'b01);

    // Jump flavours.
    lane(0, 32'h184, I_JALR); lane(1, 32'h188, I_RET);
    push(4'd0, 4'd0, 32'h180, I_ADD);
    push(4'd6, 4'd12, 32'h184, I_JALR);
    step(2'b11);
    lane(0, 32'h300, I_JAL); lane(1, 32'h304, I_CJR, 1'b1);
    push(4'd6, 4'd13, 32'h188, I_RET);
    push(4'd0, 4'd9, 32'h300, I_JAL);
    step(2'b11);

    // Exception on the youngest lane; trap fields ride with it.
    lane(0, 32'h400, I_CJALR, 1'b1); lane(1, 32'h402, I_ADD);
    exc = 2'b10; cause = 5'd2; tval = 32'hdeadbeef; priv = 2'd3;
    push(4'd6, 4'd10, 32'h304, I_CJR);
    push(4'd6, 4'd8, 32'h400, I_CJALR);
    step(2'b11);
    lane(0, 32'h500, I_ADD); lane(1, 32'h504, I_ADD);
    cause = 5'd7; tval = 32'h1234; priv = 2'd1;
    push(4'd1, 4'd1, 32'h402, I_ADD, 5'd2, 32'hdeadbeef, 2'd3);
    push(4'd0, 4'd0, 32'h500, I_ADD);
    step(2'b11);

    // Interrupt outranks ERET.
    lane(0, 32'h600, I_MRET);
    intr = 2'b01; cause = 5'd3; priv = 2'd3;
    push(4'd0, 4'd0, 32'h504, I_ADD);
    step(2'b01);
    lane(0, 32'h604, I_BGE);
    push(4'd2, 4'd2, 32'h600, I_MRET, 5'd3, 32'h0, 2'd3);
    step(2'b01);

    // Flush with no retirement drains BGE as not taken.
    push(4'd4, 4'd4, 32'h604, I_BGE);
    step(2'b00, 1'b1);
    chk("flush_pend3", 64'(if3.pending_o), 64'd0);
    chk("flush_pend4", 64'(if4.pending_o), 64'd0);

    // Flush alongside retirement is deferred to the new youngest entry.
    lane(0, 32'h700, I_ADD);
    step(2'b01);
    lane(0, 32'h704, I_ADD); lane(1, 32'h708, I_BGE);
    push(4'd0, 4'd0, 32'h700, I_ADD);
    push(4'd0, 4'd0, 32'h704, I_ADD);
    step(2'b11, 1'b1);
    push(4'd4, 4'd4, 32'h708, I_BGE);
    step(2'b00);
    chk("lat_pend", 64'(if4.pending_o), 64'd0);

    // Latched flush survives a following retirement.
    lane(0, 32'h800, I_ADD);
    step(2'b01, 1'b1);
    lane(0, 32'h900, I_BEQ);
    push(4'd0, 4'd0, 32'h800, I_ADD);
    step(2'b01);
    push(4'd4, 4'd4, 32'h900, I_BEQ);
    step(2'b00);

    // Flush with nothing pending is a no-op.
    step(2'b00, 1'b1);
    chk("noop_flush_pend", 64'(if3.pending_o), 64'd0);

    // Compressed branches: fall-through by 2, then taken.
    lane(0, 32'ha00, I_CBEQZ, 1'b1); lane(1, 32'ha02, I_CBNEZ, 1'b1);
    push(4'd4, 4'd4, 32'ha00, I_CBEQZ);
    step(2'b11);
    lane(0, 32'ha40, I_ADD);
    push(4'd5, 4'd5, 32'ha02, I_CBNEZ);
    step(2'b01);

    // Reset discards the held ADD at 0xa40.
    rst = 1'b1;
    step(2'b00);
    rst = 1'b0;
    chk("rst_valid3", 64'(if3.valid_o), 64'd0);
    chk("rst_pend3", 64'(if3.pending_o), 64'd0);
    chk("rst_valid4", 64'(if4.valid_o), 64'd0);
    chk("rst_pend4", 64'(if4.pending_o), 64'd0);
    lane(0, 32'hb00, I_ADD); lane(1, 32'hb04, I_ADD);
    push(4'd0, 4'd0, 32'hb00, I_ADD);
    step(2'b11);
    push(4'd0, 4'd0, 32'hb04, I_ADD);
    step(2'b00, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("drain3", 64'(exp3.size()), 64'd0);
    chk("drain4", 64'(exp4.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mure_itype_resolver.md
Name: mure_itype_resolver

Overview:
- Multi-retire itype classifier feeding the uop FIFO.
- Accepts up to NRET retired instructions per cycle and classifies each one per the trace spec itype table.
- Supports 3-bit and 4-bit itype encodings.
- Resolves taken/not-taken branches by comparing each instruction's successor PC, so every instruction is held until its successor retires or a flush arrives.

Parameters:
- NRET, 2, retire lanes per cycle (≥1). Lane 0 is the oldest.
- ITYPE_LEN, 3, itype width. Only 3 or 4 is legal. 4 enables the extended codes 8–15.
- XLEN, 32, address width.
- INST_LEN, 32, instruction width.
- CAUSE_LEN, 5, trap cause width.
- PRIV_LEN, 2, privilege width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  NRET  lane valid; valid lanes are contiguous from lane 0
- pc_i  in  NRET×XLEN  retired PC
- inst_data_i  in  NRET×INST_LEN  instruction bits
- compressed_i  in  NRET  16-bit instruction
- exception_i  in  NRET  lane trapped with exception
- interrupt_i  in  NRET  interrupt taken after lane
- cause_i  in  CAUSE_LEN  trap cause (shared)
- tval_i  in  XLEN  trap value (shared)
- priv_i  in  PRIV_LEN  privilege (shared)
- flush_i  in  1  drain the pending entry
- valid_o  out  NRET  output lane valid, contiguous from lane 0
- uop_o  out  NRET×uop_entry_s  classified entries, oldest in lane 0
- pending_o  out  1  a held entry exists

Behaviour:
- Reset (synchronous): valid_o=0, uop_o=0, pending_o=0, pending register and flush-latch cleared. Reset mid-stream discards the held entry without emitting it.
- Classification, highest priority first:
  - exception → EXC(1)
  - interrupt → INT(2)
  - MRET/SRET/URET → ERET(3)
  - BEQ/BNE/BLT/BGE/BLTU/BGEU/C.BEQZ/C.BNEZ → TB(5) if successor PC ≠ pc+(compressed?2:4), else NTB(4)
- ITYPE_LEN=3: JALR/C.JR/C.JALR → UIJ(6). Everything else → STD(0).
- ITYPE_LEN=4, uninferable jumps (JALR/C.JR/C.JALR). "Link" means x1 or x5.
  - rd link, rs1 link, rd≠rs1 → CRS(12)
  - rd link → UC(8)
  - rs1 link → RET(13)
  - rd=x0 → UIJ(10)
  - else → OUIJ(14)
- ITYPE_LEN=4, inferable jumps (JAL/C.J/C.JAL):
  - rd link → IC(9)
  - rd=x0 → IJ(11)
  - else → OIJ(15)
- Successor of lane k is lane k+1 in the same cycle. The successor of the last valid lane m−1 is lane 0 of the next cycle that has any valid_i.
- Cycle t with m>0 valid lanes, observed at cycle t+1:
  - Emitted, in order: the pending entry (if any), then lanes 0..m−2.
  - Lane m−1 becomes pending.
  - Emitted count ≤ NRET always.
  - Latency is exactly one cycle after the successor arrives.
- Cycle t with m=0: outputs are invalid at t+1 and pending is held indefinitely.
- The itype field zero-extends into uop_entry_s.itype. cause/tval/priv are copied only on EXC/INT lanes, otherwise 0.
- flush_i:
  - With no valid_i: the pending entry is emitted at t+1 in lane 0, with a branch resolved NTB. pending_o drops.
  - With valid_i in the same cycle: normal processing, the flush is latched, and it is applied at t+1 to the new pending entry (unless valid_i arrives again, in which case the latch persists).
  - Flush with nothing pending has no effect.
- Non-contiguous valid_i is illegal (assertion).
- More than one exception/interrupt per cycle is illegal (assertion).

Decomposition:
- mure_pkg gains:
  - itype4_e, with codes 0–15 (UC=8, IC=9, UIJ=10, IJ=11, CRS=12, RET=13, OUIJ=14, OIJ=15).
  - uop_entry_s with itype widened to 4 bits.
  - Mask/match constants MASK/MATCH_JAL (0x7f/0x6f), C_J (0xe003/0xa001), C_JAL (0xe003/0x2001).
  - Register constant X_T0=5.
- One combinational sub-module, mure_itype_classify: inputs inst, compressed, exception, interrupt, taken; output itype. One instance per lane plus one for the pending entry.

Test Plan:
- NRET=2, cycle 0: lane0 BEQ pc=0x100, lane1 ADD pc=0x104. Cycle 1: lane0 pc=0x108. Required result:
  - Cycle 1 output: lane0 itype=NTB(4) pc=0x100.
  - Cycle 2 output: ADD STD.
- BNE pc=0x200 alone. Next retire two idle cycles later at pc=0x180. Required result:
  - pending_o=1 throughout the gap.
  - TB(5) emitted one cycle after pc=0x180 arrives.
- ITYPE_LEN=4, JALR rd=x1 rs1=x5 → CRS(12). JALR rd=x0 rs1=x1 → RET(13). JAL rd=x1 → IC(9). C.JR rs1=x6 → UIJ(10).
- ITYPE_LEN=3, C.JALR → UIJ(6). Exception lane with cause=2, tval=0xdeadbeef → EXC(1), with cause and tval copied. ADD lanes → cause/tval=0.
- Pending BGE. flush_i=1 with valid_i=0 → next cycle BGE emitted as NTB, pending_o=0. Repeat with flush_i and valid_i together → the new last lane is emitted one cycle later.
- Pending entry present, assert rst_i → next cycle valid_o=0, pending_o=0. The following retirement emits no stale entry.
